// File: rtl/aes_sub_sched.sv
// Shares one 4-byte S-box lane between a 128-bit round SubBytes requester and a
// 32-bit key-expansion SubWord requester, one 32-bit word per lane operation.
module aes_sub_sched #(
    parameter bit FAIR = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rnd_valid,
    input  logic [127:0] rnd_data,
    output logic         rnd_ready,
    output logic         rnd_done,
    output logic [127:0] rnd_result,
    input  logic         key_valid,
    input  logic [31:0]  key_data,
    output logic         key_ready,
    output logic         key_done,
    output logic [31:0]  key_result,
    output logic         lane_start,
    output logic [31:0]  lane_data,
    input  logic         lane_finished,
    input  logic [31:0]  lane_result,
    output logic         busy
);

    // state | meaning
    // IDLE  | arbitrate and accept one job
    // ISSUE | present job word BEAT to the lane, start low
    // WAIT  | start high, wait for lane_finished
    // DONE  | one-cycle done pulse to the owner
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t         r_state;
    logic           r_own;          // 1 = round job, 0 = key job
    logic [1:0]     r_beat;
    logic           r_last_rnd;     // last served requester was round
    logic [127:0]   r_job;
    logic [127:0]   r_rnd_result;
    logic [31:0]    r_key_result;

    logic           w_idle;
    logic           w_key_wins;
    logic           w_last_beat;
    logic [31:0]    w_word;

    assign w_idle      = (r_state == IDLE);
    assign w_key_wins  = key_valid & (~rnd_valid | ~FAIR | r_last_rnd);
    assign w_last_beat = ~r_own | (r_beat == 2'd3);
    // Beat 0 is the top word, so the word index is the bitwise inverse of BEAT.
    assign w_word      = r_job[{~r_beat, 5'd0} +: 32];

    assign key_ready   = rst_n & w_idle & w_key_wins;
    assign rnd_ready   = rst_n & w_idle & rnd_valid & ~w_key_wins;
    assign lane_start  = (r_state == WAIT);
    assign lane_data   = ((r_state == ISSUE) || (r_state == WAIT)) ? w_word : 32'd0;
    assign rnd_done    = (r_state == DONE) & r_own;
    assign key_done    = (r_state == DONE) & ~r_own;
    assign busy        = ~w_idle;
    assign rnd_result  = r_rnd_result;
    assign key_result  = r_key_result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_own        <= 1'b0;
            r_beat       <= 2'd0;
            r_last_rnd   <= 1'b1;
            r_job        <= '0;
            r_rnd_result <= '0;
            r_key_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (key_ready) begin
                        r_job   <= {key_data, 96'd0};
                        r_own   <= 1'b0;
                        r_beat  <= 2'd0;
                        r_state <= ISSUE;
                    end else if (rnd_ready) begin
                        r_job   <= rnd_data;
                        r_own   <= 1'b1;
                        r_beat  <= 2'd0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    if (lane_finished) begin
                        if (w_last_beat) begin
                            // Results are published only on completion so they stay
                            // stable between done pulses.
                            if (r_own) r_rnd_result <= {r_job[127:32], lane_result};
                            else       r_key_result <= lane_result;
                            r_state <= DONE;
                        end else begin
                            r_job[{~r_beat, 5'd0} +: 32] <= lane_result;
                            r_beat  <= r_beat + 2'd1;
                            r_state <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    r_last_rnd <= r_own;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_sub_sched.sv
// Directed bench: a fair and a fixed-priority instance share requester inputs,
// each driving its own S-box lane model with a programmable finish delay.
module tb_aes_sub_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rnd_valid, key_valid;
    logic [127:0] rnd_data;
    logic [31:0]  key_data;

    logic         rnd_ready_f, rnd_done_f, key_ready_f, key_done_f, lane_start_f, lane_finished_f, busy_f;
    logic [127:0] rnd_result_f;
    logic [31:0]  key_result_f, lane_data_f, lane_result_f;
    logic         rnd_ready_p, rnd_done_p, key_ready_p, key_done_p, lane_start_p, lane_finished_p, busy_p;
    logic [127:0] rnd_result_p;
    logic [31:0]  key_result_p, lane_data_p, lane_result_p;

    logic [0:255][7:0] sbox_tbl;
    int cyc = 0;
    int fin_delay = 0;
    int cnt_f = 0, cnt_p = 0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_sub_sched #(.FAIR(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n),
        .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rnd_ready_f),
        .rnd_done(rnd_done_f), .rnd_result(rnd_result_f),
        .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready_f),
        .key_done(key_done_f), .key_result(key_result_f),
        .lane_start(lane_start_f), .lane_data(lane_data_f),
        .lane_finished(lane_finished_f), .lane_result(lane_result_f), .busy(busy_f));

    aes_sub_sched #(.FAIR(1'b0)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rnd_ready_p),
        .rnd_done(rnd_done_p), .rnd_result(rnd_result_p),
        .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready_p),
        .key_done(key_done_p), .key_result(key_result_p),
        .lane_start(lane_start_p), .lane_data(lane_data_p),
        .lane_finished(lane_finished_p), .lane_result(lane_result_p), .busy(busy_p));

    // Lane model: real S-box, finishes after fin_delay extra cycles of start.
    always @(posedge clk) begin
        cnt_f <= lane_start_f ? cnt_f + 1 : 0;
        cnt_p <= lane_start_p ? cnt_p + 1 : 0;
    end
    assign lane_finished_f = lane_start_f && (cnt_f >= fin_delay);
    assign lane_finished_p = lane_start_p && (cnt_p >= fin_delay);
    assign lane_result_f = {sbox_tbl[lane_data_f[31:24]], sbox_tbl[lane_data_f[23:16]],
                            sbox_tbl[lane_data_f[15:8]],  sbox_tbl[lane_data_f[7:0]]};
    assign lane_result_p = {sbox_tbl[lane_data_p[31:24]], sbox_tbl[lane_data_p[23:16]],
                            sbox_tbl[lane_data_p[15:8]],  sbox_tbl[lane_data_p[7:0]]};

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; rnd_valid = 1'b0; key_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0; rnd_valid = 1'b1; key_valid = 1'b1;
        rnd_data = 128'h1; key_data = 32'h1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({rnd_ready_f, key_ready_f, busy_f, lane_start_f, rnd_done_f, key_done_f} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {rnd_ready_f, key_ready_f, busy_f, lane_start_f, rnd_done_f, key_done_f});
        end
        checks++;
        if ({lane_data_f, key_result_f, rnd_result_f} !== 192'd0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h want 0", lane_data_f, key_result_f, rnd_result_f);
        end
        rnd_valid = 1'b0; key_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (busy_f !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy got %b want 0", busy_f);
        end
    endtask

    task automatic test_key_job(input logic [31:0] d, input logic [31:0] exp);
        int c0, cd;
        logic [127:0] rnd_before;
        rnd_before = rnd_result_f;
        fin_delay = 0;
        @(negedge clk);
        key_valid = 1'b1; key_data = d;
        #1;
        checks++;
        if (key_ready_f !== 1'b1) begin
            errors++;
            $display("FAIL key_ready got %b want 1", key_ready_f);
        end
        c0 = cyc;
        @(negedge clk);
        key_valid = 1'b0; key_data = 32'd0;
        cd = -1;
        for (int i = 0; i < 40 && cd < 0; i++) begin
            #1;
            if (key_done_f) cd = cyc;
            else @(negedge clk);
        end
        checks++;
        if (cd - c0 != 3) begin
            errors++;
            $display("FAIL key_latency got %0d want 3", cd - c0);
        end
        checks++;
        if (key_result_f !== exp) begin
            errors++;
            $display("FAIL key_result got %h want %h", key_result_f, exp);
        end
        @(negedge clk); #1;
        checks++;
        if (key_done_f !== 1'b0) begin
            errors++;
            $display("FAIL key_done_width got %b want 0", key_done_f);
        end
        checks++;
        if (rnd_result_f !== rnd_before) begin
            errors++;
            $display("FAIL key_rnd_stable got %h want %h", rnd_result_f, rnd_before);
        end
    endtask

    task automatic test_rnd_job(input logic [127:0] d, input logic [127:0] exp,
                                input int delay, input int exp_lat);
        int c0, cd, starts, run, runs, runs_bad, kseen;
        logic prev;
        logic [31:0] words [4];
        logic [31:0] key_before;
        key_before = key_result_f;
        fin_delay = delay;
        starts = 0; run = 0; runs = 0; runs_bad = 0; kseen = 0; prev = 1'b0; cd = -1;
        for (int k = 0; k < 4; k++) words[k] = 32'd0;
        @(negedge clk);
        rnd_valid = 1'b1; rnd_data = d;
        #1;
        checks++;
        if (rnd_ready_f !== 1'b1) begin
            errors++;
            $display("FAIL rnd_ready got %b want 1", rnd_ready_f);
        end
        c0 = cyc;
        @(negedge clk);
        rnd_valid = 1'b0; rnd_data = '0;
        key_valid = 1'b1; key_data = 32'hDEADBEEF;   // dropped before it can be granted
        for (int i = 0; i < 100 && cd < 0; i++) begin
            #1;
            if (key_ready_f || key_done_f) kseen++;
            if (lane_start_f) begin
                if (!prev) begin
                    if (starts < 4) words[starts] = lane_data_f;
                    starts++;
                end
                run++;
            end else if (prev) begin
                if (run != delay + 1) runs_bad++;
                runs++;
                run = 0;
            end
            prev = lane_start_f;
            if (i == 2) key_valid = 1'b0;
            if (rnd_done_f) cd = cyc;
            else @(negedge clk);
        end
        checks++;
        if (cd - c0 != exp_lat) begin
            errors++;
            $display("FAIL rnd_latency got %0d want %0d", cd - c0, exp_lat);
        end
        checks++;
        if (rnd_result_f !== exp) begin
            errors++;
            $display("FAIL rnd_result got %h want %h", rnd_result_f, exp);
        end
        checks++;
        if ({words[0], words[1], words[2], words[3]} !== d || starts != 4) begin
            errors++;
            $display("FAIL lane_words got %h %h %h %h (%0d starts) want %h",
                     words[0], words[1], words[2], words[3], starts, d);
        end
        checks++;
        if (runs != 4 || runs_bad != 0) begin
            errors++;
            $display("FAIL lane_start_runs got %0d runs %0d bad want 4 runs 0 bad", runs, runs_bad);
        end
        @(negedge clk); #1;
        checks++;
        if (rnd_done_f !== 1'b0) begin
            errors++;
            $display("FAIL rnd_done_width got %b want 0", rnd_done_f);
        end
        repeat (8) begin
            @(negedge clk); #1;
            if (key_done_f) kseen++;
        end
        checks++;
        if (kseen != 0) begin
            errors++;
            $display("FAIL dropped_key_effect got %0d events want 0", kseen);
        end
        checks++;
        if (key_result_f !== key_before) begin
            errors++;
            $display("FAIL rnd_key_stable got %h want %h", key_result_f, key_before);
        end
    endtask

    task automatic test_arbitration;
        int nf, pk, pr, both;
        logic [3:0] seq;
        nf = 0; pk = 0; pr = 0; both = 0; seq = 4'd0;
        fin_delay = 0;
        do_reset();
        @(negedge clk);
        rnd_valid = 1'b1; key_valid = 1'b1;
        rnd_data = 128'h00112233_44556677_8899AABB_CCDDEEFF; key_data = 32'h0053C1FF;
        for (int i = 0; i < 60 && nf < 4; i++) begin
            #1;
            if (key_ready_f && rnd_ready_f) both++;
            if (key_ready_f) begin
                seq[nf] = 1'b0; nf++;
            end else if (rnd_ready_f) begin
                seq[nf] = 1'b1; nf++;
            end
            if (key_ready_p) pk++;
            if (rnd_ready_p) pr++;
            @(negedge clk);
        end
        rnd_valid = 1'b0; key_valid = 1'b0;
        checks++;
        if (nf != 4 || seq !== 4'b1010) begin
            errors++;
            $display("FAIL fair_order got %0d grants seq %b want 4 grants seq 1010", nf, seq);
        end
        checks++;
        if (both != 0) begin
            errors++;
            $display("FAIL ready_onehot got %0d both-high cycles want 0", both);
        end
        checks++;
        if (pk != 5 || pr != 0) begin
            errors++;
            $display("FAIL fixed_prio got key %0d rnd %0d want key 5 rnd 0", pk, pr);
        end
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int rises, rseen;
        logic prev;
        rises = 0; rseen = 0; prev = 1'b0;
        fin_delay = 4;
        @(negedge clk);
        rnd_valid = 1'b1; rnd_data = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        @(negedge clk);
        rnd_valid = 1'b0;
        for (int i = 0; i < 100 && rises < 3; i++) begin
            #1;
            if (lane_start_f && !prev) rises++;
            prev = lane_start_f;
            if (rises < 3) @(negedge clk);
        end
        checks++;
        if (rises != 3) begin
            errors++;
            $display("FAIL mid_reach_beat2 got %0d starts want 3", rises);
        end
        rst_n = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({rnd_ready_f, key_ready_f, busy_f, lane_start_f, rnd_done_f, key_done_f} !== 6'b0 ||
            {lane_data_f, key_result_f, rnd_result_f} !== 192'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got ctrl %b data %h/%h/%h want 0",
                     {rnd_ready_f, key_ready_f, busy_f, lane_start_f, rnd_done_f, key_done_f},
                     lane_data_f, key_result_f, rnd_result_f);
        end
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk); #1;
            if (rnd_done_f || lane_start_f) rseen++;
        end
        checks++;
        if (rseen != 0) begin
            errors++;
            $display("FAIL mid_abandon got %0d events want 0", rseen);
        end
        test_key_job(32'h0053C1FF, 32'h63ED7816);
    endtask

    initial begin
        sbox_tbl = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
                    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
                    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
                    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
                    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
                    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
                    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
                    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        rst_n = 1'b0; rnd_valid = 1'b0; key_valid = 1'b0; rnd_data = '0; key_data = '0;
        test_reset();
        test_key_job(32'h0053C1FF, 32'h63ED7816);
        test_rnd_job(128'h00112233_44556677_8899AABB_CCDDEEFF,
                     128'h638293c3_1bfc33f5_c4eeacea_4bc12816, 0, 9);
        test_rnd_job(128'h53C1FF00_00FF53C1_C100FF53_FF53C100,
                     128'hED781663_6316ED78_786316ED_16ED7863, 4, 25);
        test_arbitration();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
